// File: rtl/div_top_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : div_top_iter_if
// Description : Operand/result bundle for the iterative unsigned divider.
//               The master drives the operands a/b; the slave (divider)
//               returns quotient q, remainder r and valid.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_top_iter_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             valid;

  modport master (
    output a,
    output b,
    input  q,
    input  r,
    input  valid
  );

  modport slave (
    input  a,
    input  b,
    output q,
    output r,
    output valid
  );
endinterface : div_top_iter_if
`default_nettype wire

// File: rtl/div_top_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_top_iter
// Description : Free-running restoring shift-subtract unsigned divider.
//               Recomputes q = a / b and r = a % b whenever the applied
//               operands differ from the last latched pair, one quotient
//               bit per clock, MSB first. Results are registered and held
//               between computations.
// Revision    : 1.0 - initial release
// ============================================================================
module div_top_iter #(
  parameter int WIDTH = 6
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  div_top_iter_if.slave div_if
);

  localparam int             CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  C_CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]  C_CNT_LAST = CW'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a_l;
  logic [WIDTH-1:0] r_b_l;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH:0]   r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_force_start;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_valid;

  logic             w_start;
  logic             w_finish;
  logic             w_ge;
  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH:0]   w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: start on any operand change (or first cycle after
  // reset), finish when the last quotient bit is being produced.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_force_start || (div_if.a != r_a_l) || (div_if.b != r_b_l)) begin
          w_start      = 1'b1;
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == C_CNT_LAST) begin
          w_finish     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // One restoring-division step. The extra remainder bit keeps the
  // compare against b_l from ever overflowing; with b_l == 0 every step
  // subtracts nothing, giving q = all ones and r = a.
  always_comb begin
    w_rem_shift = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
    w_ge        = (w_rem_shift >= {1'b0, r_b_l});
    w_rem_next  = w_ge ? (w_rem_shift - {1'b0, r_b_l}) : w_rem_shift;
    w_quo_next  = {r_quo[WIDTH-2:0], w_ge};
  end

  // Operand latches, working registers and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_l         <= '0;
      r_b_l         <= '0;
      r_dvd         <= '0;
      r_quo         <= '0;
      r_rem         <= '0;
      r_cnt         <= '0;
      r_force_start <= 1'b1;
      r_q           <= '0;
      r_r           <= '0;
      r_valid       <= 1'b0;
    end else if (w_start) begin
      r_a_l         <= div_if.a;
      r_b_l         <= div_if.b;
      r_dvd         <= div_if.a;
      r_quo         <= '0;
      r_rem         <= '0;
      r_cnt         <= C_CNT_LOAD;
      r_force_start <= 1'b0;
      r_valid       <= 1'b0;
    end else if (r_state == BUSY) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
      r_cnt <= r_cnt - C_CNT_LAST;
      if (w_finish) begin
        r_q     <= w_quo_next;
        r_r     <= w_rem_next[WIDTH-1:0];
        r_valid <= 1'b1;
      end
    end
  end

  assign div_if.q     = r_q;
  assign div_if.r     = r_r;
  assign div_if.valid = r_valid;

endmodule : div_top_iter
`default_nettype wire

// File: tb/tb_div_top_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_top_iter
// Description : Directed self-checking bench for div_top_iter (WIDTH = 6).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_top_iter;

  localparam int WIDTH = 6;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  div_top_iter_if #(.WIDTH(WIDTH)) dif ();

  div_top_iter #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_if (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply operands on a falling edge, then count falling edges until valid
  // is seen high (0 if it never rises within the budget).
  task automatic apply_and_wait(input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb,
                                output int n);
    @(negedge clk);
    dif.a = na;
    dif.b = nb;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (dif.valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    dif.a = 6'd0;
    dif.b = 6'd1;
    repeat (2) @(negedge clk);
    total++;
    if ({dif.q, dif.r, dif.valid} !== 13'd0) begin
      bad++;
      $display("FAIL reset_vals: got q=%0d r=%0d valid=%0b, want q=0 r=0 valid=0",
               dif.q, dif.r, dif.valid);
    end
    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (dif.valid === 1'b1) begin
        n = i;
        break;
      end
    end
    total++;
    if (n !== WIDTH + 1) begin
      bad++;
      $display("FAIL reset_first_latency: got %0d cycles, want %0d", n, WIDTH + 1);
    end
    total++;
    if (dif.q !== 6'd0 || dif.r !== 6'd0) begin
      bad++;
      $display("FAIL reset_first_result: got q=%0d r=%0d, want q=0 r=0", dif.q, dif.r);
    end
  endtask

  task automatic test_basic();
    int n;
    @(negedge clk);
    dif.a = 6'd31;
    dif.b = 6'd5;
    @(negedge clk);
    total++;
    if (dif.valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_valid_drop: got valid=%0b, want 0", dif.valid);
    end
    total++;
    if (dif.q !== 6'd0 || dif.r !== 6'd0) begin
      bad++;
      $display("FAIL basic_hold_old: got q=%0d r=%0d, want q=0 r=0", dif.q, dif.r);
    end
    n = 0;
    for (int i = 2; i <= 20; i++) begin
      @(negedge clk);
      if (dif.valid === 1'b1) begin
        n = i;
        break;
      end
    end
    total++;
    if (n !== WIDTH + 1) begin
      bad++;
      $display("FAIL basic_latency: got %0d cycles, want %0d", n, WIDTH + 1);
    end
    total++;
    if (dif.q !== 6'd6 || dif.r !== 6'd1) begin
      bad++;
      $display("FAIL basic_31_5: got q=%0d r=%0d, want q=6 r=1", dif.q, dif.r);
    end
  endtask

  task automatic test_corners();
    int n;
    logic [WIDTH-1:0] va [3];
    logic [WIDTH-1:0] vb [3];
    logic [WIDTH-1:0] eq [3];
    logic [WIDTH-1:0] er [3];
    va = '{6'd63, 6'd5, 6'd17};
    vb = '{6'd1,  6'd9, 6'd0};
    eq = '{6'd63, 6'd0, 6'd63};
    er = '{6'd0,  6'd5, 6'd17};
    for (int k = 0; k < 3; k++) begin
      apply_and_wait(va[k], vb[k], n);
      total++;
      if (n !== WIDTH + 1) begin
        bad++;
        $display("FAIL corner_latency a=%0d b=%0d: got %0d cycles, want %0d",
                 va[k], vb[k], n, WIDTH + 1);
      end
      total++;
      if (dif.q !== eq[k] || dif.r !== er[k]) begin
        bad++;
        $display("FAIL corner a=%0d b=%0d: got q=%0d r=%0d, want q=%0d r=%0d",
                 va[k], vb[k], dif.q, dif.r, eq[k], er[k]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [WIDTH-1:0] eq;
    logic [WIDTH-1:0] er;
    for (int ia = 0; ia < 32; ia++) begin
      for (int ib = 1; ib < 32; ib++) begin
        @(negedge clk);
        dif.a = WIDTH'(ia);
        dif.b = WIDTH'(ib);
        repeat (10) @(negedge clk);
        eq = WIDTH'(ia / ib);
        er = WIDTH'(ia % ib);
        total++;
        if (dif.q !== eq || dif.r !== er || dif.valid !== 1'b1) begin
          bad++;
          $display("FAIL sweep a=%0d b=%0d: got q=%0d r=%0d valid=%0b, want q=%0d r=%0d valid=1",
                   ia, ib, dif.q, dif.r, dif.valid, eq, er);
        end
      end
    end
  endtask

  task automatic test_change_busy();
    @(negedge clk);
    dif.a = 6'd0;
    dif.b = 6'd7;
    repeat (10) @(negedge clk);
    dif.a = 6'd20;
    repeat (3) @(negedge clk);
    dif.a = 6'd45;
    repeat (4) @(negedge clk);
    total++;
    if (dif.valid !== 1'b1 || dif.q !== 6'd2 || dif.r !== 6'd6) begin
      bad++;
      $display("FAIL busy_first: got q=%0d r=%0d valid=%0b, want q=2 r=6 valid=1",
               dif.q, dif.r, dif.valid);
    end
    @(negedge clk);
    total++;
    if (dif.valid !== 1'b0 || dif.q !== 6'd2 || dif.r !== 6'd6) begin
      bad++;
      $display("FAIL busy_restart: got q=%0d r=%0d valid=%0b, want q=2 r=6 valid=0",
               dif.q, dif.r, dif.valid);
    end
    repeat (6) @(negedge clk);
    total++;
    if (dif.valid !== 1'b1 || dif.q !== 6'd6 || dif.r !== 6'd3) begin
      bad++;
      $display("FAIL busy_second: got q=%0d r=%0d valid=%0b, want q=6 r=3 valid=1",
               dif.q, dif.r, dif.valid);
    end
    repeat (5) @(negedge clk);
    total++;
    if (dif.valid !== 1'b1 || dif.q !== 6'd6 || dif.r !== 6'd3) begin
      bad++;
      $display("FAIL busy_hold: got q=%0d r=%0d valid=%0b, want q=6 r=3 valid=1",
               dif.q, dif.r, dif.valid);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    dif.a = 6'd50;
    dif.b = 6'd3;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({dif.q, dif.r, dif.valid} !== 13'd0) begin
      bad++;
      $display("FAIL reset_async: got q=%0d r=%0d valid=%0b, want q=0 r=0 valid=0",
               dif.q, dif.r, dif.valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (dif.valid === 1'b1) begin
        n = i;
        break;
      end
    end
    total++;
    if (n !== WIDTH + 1) begin
      bad++;
      $display("FAIL reset_mid_latency: got %0d cycles, want %0d", n, WIDTH + 1);
    end
    total++;
    if (dif.q !== 6'd16 || dif.r !== 6'd2) begin
      bad++;
      $display("FAIL reset_mid_result: got q=%0d r=%0d, want q=16 r=2", dif.q, dif.r);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_corners();
    test_change_busy();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_div_top_iter
`default_nettype wire
